// File: rtl/imem_boot_pkg.sv
// Shared types and the rotate-xor checksum step for the PikaRISC image loader.
package imem_boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_VERIFY = 3'd2,
      ST_RUN    = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int CSUM_MAX_W = 64;

   // c' = rotl1(c) ^ w within the low 'width' bits; inputs must be zero above width.
   function automatic logic [CSUM_MAX_W-1:0] csum_step(input logic [CSUM_MAX_W-1:0] c,
                                                        input logic [CSUM_MAX_W-1:0] w,
                                                        input int width);
      logic [CSUM_MAX_W-1:0] mask;
      logic [CSUM_MAX_W-1:0] rot;
      mask = (width >= CSUM_MAX_W) ? {CSUM_MAX_W{1'b1}} : ((64'd1 << width) - 64'd1);
      rot  = ((c << 1) | ((c >> (width - 1)) & 64'd1)) & mask;
      return rot ^ w;
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Image-source handshake plus instruction-memory write/read port of the boot loader.
interface imem_boot_loader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic              src_valid;
   logic              src_ready;
   logic [DATA_W-1:0] src_data;
   logic              src_last;
   logic              imem_wr_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_wr_data;
   logic [DATA_W-1:0] imem_rd_data;

   modport master (
      input  src_valid, src_data, src_last, imem_rd_data,
      output src_ready, imem_wr_en, imem_addr, imem_wr_data
   );

   modport slave (
      output src_valid, src_data, src_last, imem_rd_data,
      input  src_ready, imem_wr_en, imem_addr, imem_wr_data
   );
endinterface

// File: rtl/imem_boot_loader_checksum.sv
// boot_checksum: rotate-xor accumulator with synchronous clear and enable.
module boot_checksum
   import imem_boot_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] sum,
   output logic [DATA_W-1:0] sum_nxt
);
   logic [CSUM_MAX_W-1:0] step_s;

   assign step_s  = csum_step(CSUM_MAX_W'(sum), CSUM_MAX_W'(data), DATA_W);
   assign sum_nxt = step_s[DATA_W-1:0];

   generate
      if (DATA_W < CSUM_MAX_W) begin : g_tail
         logic tail_unused;
         assign tail_unused = ^step_s[CSUM_MAX_W-1:DATA_W];
      end
   endgenerate

   // Accumulator register
   always_ff @(posedge clk) begin
      if (!reset) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum_nxt;
      end
   end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams an image into imem, then releases the core for a cycle budget.
// Optional read-back checksum pass enabled by defining IMEM_BOOT_VERIFY_EN.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int CYC_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CYC_W-1:0]  run_cycles,
   imem_boot_loader_if.master bus,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   load_count,
   output logic [CYC_W-1:0]  cycle_count,
   output logic              error
);
   localparam logic [ADDR_W:0]  DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]  ONE_A   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [CYC_W-1:0] ONE_C   = {{(CYC_W-1){1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic [ADDR_W:0]   ptr;
   logic [CYC_W-1:0]  budget;
   logic [CYC_W-1:0]  cyc;
   logic              err;

   logic              start_ok_s;
   logic              accept_s;
   logic              full_s;
   logic              write_s;
   logic [CYC_W-1:0]  cyc_inc_s;
   logic              run_end_s;
   logic              verify_last_s;
   logic              verify_fail_s;
   logic [ADDR_W-1:0] verify_addr_s;

   assign start_ok_s = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign accept_s   = (state == ST_LOAD) && bus.src_valid;
   assign full_s     = (ptr == DEPTH_C);
   assign write_s    = accept_s && !full_s;
   assign cyc_inc_s  = cyc + ONE_C;
   assign run_end_s  = (state == ST_RUN) && (budget != '0) && (cyc_inc_s == budget);

`ifdef IMEM_BOOT_VERIFY_EN
   logic [ADDR_W:0]   vptr;
   logic [DATA_W-1:0] load_sum;
   logic [DATA_W-1:0] load_nxt_unused;
   logic [DATA_W-1:0] verify_sum_unused;
   logic [DATA_W-1:0] verify_nxt;

   boot_checksum #(.DATA_W(DATA_W)) u_load_sum (
      .clk     (clk),
      .reset   (reset),
      .clr     (start_ok_s),
      .en      (write_s),
      .data    (bus.src_data),
      .sum     (load_sum),
      .sum_nxt (load_nxt_unused)
   );

   boot_checksum #(.DATA_W(DATA_W)) u_verify_sum (
      .clk     (clk),
      .reset   (reset),
      .clr     (start_ok_s),
      .en      (state == ST_VERIFY),
      .data    (bus.imem_rd_data),
      .sum     (verify_sum_unused),
      .sum_nxt (verify_nxt)
   );

   // Final read-back word is folded combinationally so VERIFY lasts exactly load_count cycles.
   assign verify_last_s = (state == ST_VERIFY) && ((vptr + ONE_A) == ptr);
   assign verify_fail_s = verify_last_s && (verify_nxt != load_sum);
   assign verify_addr_s = vptr[ADDR_W-1:0];

   // Read-back pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         vptr <= '0;
      end else if (state == ST_VERIFY) begin
         vptr <= vptr + ONE_A;
      end else begin
         vptr <= '0;
      end
   end
`else
   logic rd_unused;
   assign rd_unused     = ^bus.imem_rd_data;
   assign verify_last_s = 1'b0;
   assign verify_fail_s = 1'b0;
   assign verify_addr_s = '0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_LOAD;
            else       state_nxt = ST_IDLE;
         end
         ST_LOAD: begin
            if (accept_s && bus.src_last) begin
`ifdef IMEM_BOOT_VERIFY_EN
               state_nxt = ST_VERIFY;
`else
               state_nxt = ST_RUN;
`endif
            end else begin
               state_nxt = ST_LOAD;
            end
         end
         ST_VERIFY: begin
            if (verify_fail_s)      state_nxt = ST_DONE;
            else if (verify_last_s) state_nxt = ST_RUN;
            else                    state_nxt = ST_VERIFY;
         end
         ST_RUN: begin
            if (run_end_s) state_nxt = ST_DONE;
            else           state_nxt = ST_RUN;
         end
         ST_DONE: begin
            if (start) state_nxt = ST_LOAD;
            else       state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Memory port drive; writes pass straight through in the accepting cycle
   always_comb begin
      bus.src_ready    = (state == ST_LOAD);
      bus.imem_wr_en   = write_s;
      bus.imem_wr_data = bus.src_data;
      case (state)
         ST_LOAD:   bus.imem_addr = ptr[ADDR_W-1:0];
         ST_VERIFY: bus.imem_addr = verify_addr_s;
         default:   bus.imem_addr = '0;
      endcase
   end

   // Pointer, run budget, cycle counter and sticky error
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr    <= '0;
         budget <= '0;
         cyc    <= '0;
         err    <= 1'b0;
      end else if (start_ok_s) begin
         ptr    <= '0;
         budget <= run_cycles;
         cyc    <= '0;
         err    <= 1'b0;
      end else begin
         if (write_s) ptr <= ptr + ONE_A;
         if ((accept_s && full_s) || verify_fail_s) err <= 1'b1;
         if ((state == ST_RUN) && !(&cyc)) cyc <= cyc_inc_s;
      end
   end

   assign cpu_reset   = (state == ST_RUN);
   assign busy        = (state == ST_LOAD) || (state == ST_VERIFY) || (state == ST_RUN);
   assign done        = (state == ST_DONE);
   assign load_count  = ptr;
   assign cycle_count = cyc;
   assign error       = err;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed, table-driven bench for imem_boot_loader (ADDR_W=2 so overflow is reachable).
module tb_imem_boot_loader;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 2;
   localparam int CYC_W  = 16;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [CYC_W-1:0]  run_cycles;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   load_count;
   logic [CYC_W-1:0]  cycle_count;
   logic              error;

   imem_boot_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   imem_boot_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .run_cycles  (run_cycles),
      .bus         (bus),
      .cpu_reset   (cpu_reset),
      .busy        (busy),
      .done        (done),
      .load_count  (load_count),
      .cycle_count (cycle_count),
      .error       (error)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              corrupt = 1'b0;
   int                high_cnt = 0;
   int                wr_cnt = 0;
   int                tests = 0;
   int                fails = 0;

   always @(posedge clk) begin
      if (bus.imem_wr_en === 1'b1) begin
         mem[bus.imem_addr] = bus.imem_wr_data;
         wr_cnt = wr_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (cpu_reset === 1'b1) high_cnt = high_cnt + 1;
   end

   assign bus.imem_rd_data = mem[bus.imem_addr] ^
                             ((corrupt && (bus.imem_addr == 2'd2)) ? 32'h0000_0001 : 32'h0000_0000);

   typedef struct {
      logic [CYC_W-1:0]  run;
      int                n;
      bit                gap;
      logic [DATA_W-1:0] seed;
      logic [ADDR_W:0]   exp_lc;
      logic [CYC_W-1:0]  exp_cc;
      logic              exp_err;
      int                exp_high;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input logic [CYC_W-1:0] r);
      start      = 1'b1;
      run_cycles = r;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic send_image(input logic [DATA_W-1:0] seed, input int n, input bit gap,
                             output bit busy_ok);
      busy_ok = 1'b1;
      for (int k = 0; k < n; k++) begin
         if (gap) begin
            bus.src_valid = 1'b0;
            @(negedge clk);
            busy_ok = busy_ok & busy;
         end
         bus.src_valid = 1'b1;
         bus.src_data  = seed + 32'(k) * 32'h11;
         bus.src_last  = (k == n - 1);
         busy_ok = busy_ok & busy & bus.src_ready;
         @(negedge clk);
      end
      bus.src_valid = 1'b0;
      bus.src_last  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int w;
      w = 0;
      while (!done && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s: done not seen within 300 cycles", name);
      end
   endtask

   initial begin
      bit busy_ok;
      int wr0;
      int w;

      vecs[0] = '{run:16'd10, n:4, gap:1'b0, seed:32'h0000_0011, exp_lc:3'd4, exp_cc:16'd10, exp_err:1'b0, exp_high:10};
      vecs[1] = '{run:16'd5,  n:4, gap:1'b1, seed:32'h1000_0011, exp_lc:3'd4, exp_cc:16'd5,  exp_err:1'b0, exp_high:5};
      vecs[2] = '{run:16'd3,  n:7, gap:1'b0, seed:32'h2000_0011, exp_lc:3'd4, exp_cc:16'd3,  exp_err:1'b1, exp_high:3};
      vecs[3] = '{run:16'd1,  n:1, gap:1'b0, seed:32'h3000_00AB, exp_lc:3'd1, exp_cc:16'd1,  exp_err:1'b0, exp_high:1};
      vecs[4] = '{run:16'd7,  n:2, gap:1'b1, seed:32'hCAFE_0000, exp_lc:3'd2, exp_cc:16'd7,  exp_err:1'b0, exp_high:7};

      reset = 1'b0;
      start = 1'b0;
      run_cycles = '0;
      bus.src_valid = 1'b0;
      bus.src_data  = '0;
      bus.src_last  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {bus.src_ready, bus.imem_wr_en, bus.imem_addr, cpu_reset, busy, done, error}, 64'h0);
      chk("reset_counts", {load_count, cycle_count}, 64'h0);
      reset = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_BEEF;
         pulse_start(vecs[v].run);
         high_cnt = 0;
         send_image(vecs[v].seed, vecs[v].n, vecs[v].gap, busy_ok);
         chk($sformatf("busy_load[%0d]", v), 64'(busy_ok), 64'h1);
         wait_done($sformatf("wait_done[%0d]", v));
         chk($sformatf("ctrl_done[%0d]", v), {cpu_reset, busy, done}, 64'h1);
         chk($sformatf("load_count[%0d]", v), 64'(load_count), 64'(vecs[v].exp_lc));
         chk($sformatf("cycle_count[%0d]", v), 64'(cycle_count), 64'(vecs[v].exp_cc));
         chk($sformatf("error[%0d]", v), 64'(error), 64'(vecs[v].exp_err));
         chk($sformatf("run_len[%0d]", v), 64'(high_cnt), 64'(vecs[v].exp_high));
         for (int i = 0; i < DEPTH; i++) begin
            if (i < vecs[v].n)
               chk($sformatf("imem[%0d][%0d]", v, i), 64'(mem[i]), 64'(vecs[v].seed + 32'(i) * 32'h11));
         end
         repeat (3) @(negedge clk);
         chk($sformatf("done_hold[%0d]", v), {done, 13'(cycle_count)}, {1'b1, 13'(vecs[v].exp_cc)});
      end

      // start and src_valid together in DONE: the beat must wait for LOAD
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_BEEF;
      wr0 = wr_cnt;
      bus.src_valid = 1'b1;
      bus.src_data  = 32'h0000_00A0;
      bus.src_last  = 1'b0;
      pulse_start(16'd4);
      @(negedge clk);
      bus.src_data = 32'h0000_00B0;
      bus.src_last = 1'b1;
      @(negedge clk);
      bus.src_valid = 1'b0;
      bus.src_last  = 1'b0;
      wait_done("wait_done_same");
      chk("same_cycle_writes", 64'(wr_cnt - wr0), 64'd2);
      chk("same_cycle_lc", 64'(load_count), 64'd2);
      chk("same_cycle_mem", {mem[0], mem[1]}, {32'h0000_00A0, 32'h0000_00B0});

      // reset mid-load aborts everything
      pulse_start(16'd9);
      bus.src_valid = 1'b1;
      bus.src_data  = 32'h5555_0000;
      bus.src_last  = 1'b0;
      repeat (2) @(negedge clk);
      chk("midload_lc", 64'(load_count), 64'd2);
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_ctrl", {bus.src_ready, bus.imem_wr_en, bus.imem_addr, cpu_reset, busy, done, error}, 64'h0);
      chk("midreset_counts", {load_count, cycle_count}, 64'h0);
      reset = 1'b1;
      bus.src_valid = 1'b0;
      @(negedge clk);

      // unbounded run: counter saturates, done never rises
      pulse_start(16'd0);
      send_image(32'h7777_0000, 1, 1'b0, busy_ok);
      w = 0;
      while (!cpu_reset && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("unbounded_start", {cpu_reset, 16'(cycle_count)}, {1'b1, 16'd0});
      repeat (100) @(negedge clk);
      chk("unbounded_100", 64'(cycle_count), 64'd100);
      repeat (65500) @(negedge clk);
      chk("unbounded_sat", {done, busy, cpu_reset, cycle_count}, {1'b0, 1'b1, 1'b1, 16'hFFFF});
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

`ifdef IMEM_BOOT_VERIFY_EN
      // read-back corruption must block the run
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_BEEF;
      corrupt = 1'b1;
      pulse_start(16'd10);
      high_cnt = 0;
      send_image(32'h0000_0011, 4, 1'b0, busy_ok);
      wait_done("wait_done_verify");
      chk("verify_err", {error, done}, 64'h3);
      chk("verify_no_run", 64'(high_cnt), 64'd0);
      corrupt = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
